// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage with 16x oversampling, start/stop
// validation and a self-generated oversample tick derived from sysclk.
module uart_receiver #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick_c;
  logic               rx_m;
  logic               rx_s;
  logic [3:0]         samp_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift_reg;

  assign tick_c = (div_cnt == DIV_W'(DIV - 1));

  // Free-running oversample divider, one tick every DIV cycles
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Two-flop synchronizer on the asynchronous line, idle-high reset value
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= UART_RX;
      rx_s <= rx_m;
    end
  end

  // Receive FSM; counters, shift register and all outputs are registered here
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state       <= IDLE;
      samp_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      RX_DATA     <= '0;
      RX_STATUS   <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      RX_STATUS   <= 1'b0;
      frame_error <= 1'b0;
      if (tick_c) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              samp_cnt <= '0;
              state    <= START;
              busy     <= 1'b1;
            end
          end
          START: begin
            // Mid start bit: confirm it is still low, otherwise treat as glitch
            if (samp_cnt == 4'd7) begin
              if (!rx_s) begin
                samp_cnt <= '0;
                bit_cnt  <= '0;
                state    <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
          DATA: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd15) begin
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end
            end
          end
          STOP: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd15) begin
              if (rx_s) begin
                RX_DATA   <= shift_reg;
                RX_STATUS <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
              end else begin
                frame_error <= 1'b1;
                state       <= RECOVER;
              end
            end
          end
          RECOVER: begin
            // Hold off until the line returns high so a break cannot retrigger
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed UART frames with a queue-based scoreboard;
// a negedge monitor pops one expected event per RX_STATUS/frame_error pulse.
module tb_uart_receiver;

  localparam int unsigned BIT_CYC = 160;
  localparam int unsigned LAT_LO  = 1520;
  localparam int unsigned LAT_HI  = 1532;

  logic       sysclk  = 1'b0;
  logic       reset   = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       frame_error;
  logic       busy;

  uart_receiver #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .UART_RX    (UART_RX),
    .RX_DATA    (RX_DATA),
    .RX_STATUS  (RX_STATUS),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  exp_t        sb[$];
  int unsigned status_t[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_st = 1'b0;
  logic        prev_fe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int unsigned v,
                             input int unsigned lo, input int unsigned hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, v, lo, hi, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge sysclk) begin : mon
    exp_t e;
    if (RX_STATUS || frame_error) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: RX_STATUS=%0b frame_error=%0b RX_DATA=0x%02h, none expected (cycle %0d)",
                 RX_STATUS, frame_error, RX_DATA, cyc);
      end else begin
        e = sb.pop_front();
        check("event_kind", 32'({RX_STATUS, frame_error}), e.is_err ? 32'd1 : 32'd2);
        check("rx_data", 32'(RX_DATA), 32'(e.data));
        if (e.hi != 0) check_range("latency", cyc, e.lo, e.hi);
      end
      if (RX_STATUS) status_t.push_back(cyc);
    end
    if (prev_st || prev_fe) check("pulse_width", 32'({RX_STATUS, frame_error}), 32'd0);
    prev_st = RX_STATUS;
    prev_fe = frame_error;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic expect_ev(input logic [7:0] d, input bit is_err, input bit timed);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.lo     = timed ? cyc + LAT_LO : 0;
    e.hi     = timed ? cyc + LAT_HI : 0;
    sb.push_back(e);
  endtask

  task automatic send_bits(input logic [9:0] fr, input int nbits, input int bitcyc);
    for (int i = 0; i < nbits; i++) begin
      UART_RX = fr[i];
      idle(bitcyc);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int bitcyc, input logic stop_val);
    send_bits({stop_val, d, 1'b0}, 10, bitcyc);
  endtask

  task automatic wait_not_busy(input string name, input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge sysclk);
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned gap;
    reset   = 1'b0;
    UART_RX = 1'b1;
    idle(3);
    check("reset_rx_data", 32'(RX_DATA), 32'd0);
    check("reset_status", 32'(RX_STATUS), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(50);

    // Single nominal frame
    expect_ev(8'h55, 1'b0, 1'b1);
    send_byte(8'h55, BIT_CYC, 1'b1);
    idle(200);
    check("pending_single", 32'(sb.size()), 32'd0);

    // Back-to-back frames, no idle gap
    expect_ev(8'hA3, 1'b0, 1'b1);
    send_byte(8'hA3, BIT_CYC, 1'b1);
    expect_ev(8'h0F, 1'b0, 1'b1);
    send_byte(8'h0F, BIT_CYC, 1'b1);
    idle(200);
    check("pending_b2b", 32'(sb.size()), 32'd0);
    gap = (status_t.size() >= 2) ? status_t[status_t.size()-1] - status_t[status_t.size()-2] : 0;
    check_range("b2b_gap", gap, 1590, 1610);

    // Short low glitch must be rejected at the start-bit midpoint
    UART_RX = 1'b0;
    idle(40);
    check("glitch_busy_high", 32'(busy), 32'd1);
    UART_RX = 1'b1;
    wait_not_busy("glitch_busy_low", 100);
    idle(100);

    // Stop bit low followed by a long break
    expect_ev(8'h0F, 1'b1, 1'b0);
    send_byte(8'hFF, BIT_CYC, 1'b0);
    idle(5000);
    check("break_busy", 32'(busy), 32'd1);
    check("break_rx_data", 32'(RX_DATA), 32'h0F);
    check("pending_break", 32'(sb.size()), 32'd0);
    UART_RX = 1'b1;
    wait_not_busy("recover_idle", 40);
    idle(100);
    expect_ev(8'h3C, 1'b0, 1'b1);
    send_byte(8'h3C, BIT_CYC, 1'b1);
    idle(200);
    check("pending_after_break", 32'(sb.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0x81
    send_bits({1'b1, 8'h81, 1'b0}, 5, BIT_CYC);
    UART_RX = 1'b0;
    idle(80);
    reset   = 1'b0;
    UART_RX = 1'b1;
    idle(1);
    reset = 1'b1;
    check("midreset_rx_data", 32'(RX_DATA), 32'd0);
    check("midreset_status", 32'(RX_STATUS), 32'd0);
    check("midreset_frame_error", 32'(frame_error), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    idle(2000);
    expect_ev(8'h81, 1'b0, 1'b1);
    send_byte(8'h81, BIT_CYC, 1'b1);
    idle(200);
    check("pending_after_reset", 32'(sb.size()), 32'd0);

    // Baud skew of about +/-2.5%
    expect_ev(8'hC6, 1'b0, 1'b0);
    send_byte(8'hC6, 164, 1'b1);
    idle(300);
    expect_ev(8'hC6, 1'b0, 1'b0);
    send_byte(8'hC6, 156, 1'b1);
    idle(300);
    check("pending_skew", 32'(sb.size()), 32'd0);
    check("final_rx_data", 32'(RX_DATA), 32'hC6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
